// File: rtl/ddr_lane_delay_ctrl.sv
// Delay-line sequencer for one DDR3 lane: spaced LOAD/MOVE pulse train with out-of-range abort.
// Define DDR_LANE_DELAY_CTRL_PAUSE_EN to bracket each operation with HS_IO_CLK_PAUSE.
module ddr_lane_delay_ctrl #(
    parameter int unsigned MOVE_GAP    = 4,
    parameter int unsigned PAUSE_SETUP = 2,
    parameter int unsigned PAUSE_HOLD  = 2
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_OP,
    input  logic       REQ_SEL,
    input  logic       REQ_DIR,
    input  logic [7:0] REQ_TAPS,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] MOVE_COUNT
);

    localparam int unsigned CMAX_A = (MOVE_GAP > PAUSE_SETUP) ? MOVE_GAP : PAUSE_SETUP;
    localparam int unsigned CMAX   = (CMAX_A > PAUSE_HOLD) ? CMAX_A : PAUSE_HOLD;
    localparam int          CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
`ifdef DDR_LANE_DELAY_CTRL_PAUSE_EN
        PAUSE_PRE  = 3'd1,
        PAUSE_POST = 3'd4,
`endif
        APPLY      = 3'd2,
        GAP        = 3'd3,
        FINISH     = 3'd5
    } state_t;

    // Where the sequence goes once pulses are over (normal end or abort).
`ifdef DDR_LANE_DELAY_CTRL_PAUSE_EN
    localparam state_t END_ST = PAUSE_POST;
`else
    localparam state_t END_ST = FINISH;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    taps_q, taps_d;
    logic [7:0]    mcount_q, mcount_d;
    logic          op_q, op_d;
    logic          sel_q, sel_d;
    logic          dir_q, dir_d;
    logic          abort_q, abort_d;
    logic          err_q, err_d;
    logic          load_q, move_q, done_q;
    logic          accept;
    logic          flag;

    assign REQ_READY = (state_q == IDLE) && !RESET;
    assign accept    = REQ_VALID && REQ_READY;
    assign flag      = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        taps_d  = taps_q;
        op_d    = op_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = REQ_OP;
                    sel_d   = REQ_SEL;
                    dir_d   = REQ_DIR;
                    taps_d  = REQ_TAPS;
                    abort_d = 1'b0;
                    if (!REQ_OP && (REQ_TAPS == 8'd0)) begin
                        state_d = FINISH;
                    end else begin
`ifdef DDR_LANE_DELAY_CTRL_PAUSE_EN
                        state_d = PAUSE_PRE;
                        cnt_d   = CW'(PAUSE_SETUP - 1);
`else
                        state_d = APPLY;
`endif
                    end
                end
            end
`ifdef DDR_LANE_DELAY_CTRL_PAUSE_EN
            PAUSE_PRE: begin
                if (cnt_q == '0) state_d = APPLY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            PAUSE_POST: begin
                if (cnt_q == '0) state_d = FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            APPLY: begin
                state_d = GAP;
                cnt_d   = CW'(MOVE_GAP - 2);
                if (!op_q) taps_d = taps_q - 8'd1;
            end
            GAP: begin
                // Flags are meaningless while a load settles, so only moves can abort.
                if (!op_q && flag) begin
                    abort_d = 1'b1;
                    state_d = END_ST;
                    cnt_d   = CW'(PAUSE_HOLD - 1);
                end else if (cnt_q == '0) begin
                    if (!op_q && (taps_q != 8'd0)) begin
                        state_d = APPLY;
                    end else begin
                        state_d = END_ST;
                        cnt_d   = CW'(PAUSE_HOLD - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output side effects follow the state being entered so every output is a flop.
    always_comb begin
        mcount_d = accept ? 8'd0 : mcount_q;
        err_d    = accept ? 1'b0 : err_q;
        if ((state_d == APPLY) && !op_d) mcount_d = mcount_d + 8'd1;
        if (state_d == FINISH)           err_d    = abort_d;
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            taps_q   <= 8'd0;
            mcount_q <= 8'd0;
            op_q     <= 1'b0;
            sel_q    <= 1'b0;
            dir_q    <= 1'b0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            move_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            taps_q   <= taps_d;
            mcount_q <= mcount_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            load_q   <= (state_d == APPLY) && op_d;
            move_q   <= (state_d == APPLY) && !op_d;
            done_q   <= (state_d == FINISH);
        end
    end

`ifdef DDR_LANE_DELAY_CTRL_PAUSE_EN
    logic pause_q;

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) pause_q <= 1'b0;
        else       pause_q <= (state_d != IDLE) && (state_d != FINISH);
    end

    assign HS_IO_CLK_PAUSE = pause_q;
`else
    assign HS_IO_CLK_PAUSE = 1'b0;
`endif

    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign MOVE_COUNT           = mcount_q;

endmodule

// File: tb/tb_ddr_lane_delay_ctrl.sv
// Scoreboard bench for ddr_lane_delay_ctrl: a schedule model predicts each operation,
// a monitor checks pulses and completions as the DUT produces them.
module tb_ddr_lane_delay_ctrl;

    localparam int G = 4;
`ifdef DDR_LANE_DELAY_CTRL_PAUSE_EN
    localparam int S = 2;
    localparam int H = 2;
    localparam bit PAUSE = 1'b1;
`else
    localparam int S = 0;
    localparam int H = 0;
    localparam bit PAUSE = 1'b0;
`endif
    localparam int NEVER = 1 << 20;

    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0, REQ_OP = 1'b0, REQ_SEL = 1'b0, REQ_DIR = 1'b0;
    logic [7:0] REQ_TAPS = 8'd0;
    logic       RX_DELAY_LINE_OUT_OF_RANGE = 1'b0, TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       REQ_READY, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, DONE, ERR;
    logic [7:0] MOVE_COUNT;

    ddr_lane_delay_ctrl dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_SEL(REQ_SEL), .REQ_DIR(REQ_DIR), .REQ_TAPS(REQ_TAPS),
        .DELAY_LINE_SEL(DELAY_LINE_SEL), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
        .RX_DELAY_LINE_OUT_OF_RANGE(RX_DELAY_LINE_OUT_OF_RANGE),
        .TX_DELAY_LINE_OUT_OF_RANGE(TX_DELAY_LINE_OUT_OF_RANGE),
        .DONE(DONE), .ERR(ERR), .MOVE_COUNT(MOVE_COUNT)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    typedef struct {
        int done; int err; int cnt; int loads; int pause; int sel; int dir;
    } exp_t;

    exp_t q[$];
    int   mq[$];
    int   n_vec = 0, n_err = 0;
    int   cur_acc = 0, cur_a = NEVER;
    bit   cur_sel = 1'b0;
    int   mv_seen = 0, ld_seen = 0, ps_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: MOVE k lands at S+1+k*G; the first gap cycle at or after the
    // flag rise aborts; pause covers cycles 1..DONE-1 of any non-empty operation.
    task automatic model(input bit op, input bit sel, input bit dir, input int taps,
                         input int a, input int acc);
        exp_t e;
        e.err = 0; e.cnt = 0; e.loads = 0; e.sel = sel; e.dir = dir;
        if (!op && taps == 0) begin
            e.done = 1;
        end else if (op) begin
            e.loads = 1;
            e.done  = S + G + H + 1;
        end else begin
            e.done = S + taps * G + H + 1;
            for (int k = 0; k < taps; k++) begin
                int m;
                m = S + 1 + k * G;
                mq.push_back(acc + m);
                e.cnt++;
                if (a <= m + G - 1) begin
                    e.err  = 1;
                    e.done = ((a > m + 1) ? a : m + 1) + H + 1;
                    break;
                end
            end
        end
        e.pause = (PAUSE && !(!op && taps == 0)) ? e.done - 1 : 0;
        e.done  = e.done + acc;
        q.push_back(e);
    endtask

    task automatic drive_flags();
        bit f;
        f = ((cyc - cur_acc) >= cur_a);
        if (cur_sel) begin
            TX_DELAY_LINE_OUT_OF_RANGE = f;
            RX_DELAY_LINE_OUT_OF_RANGE = 1'($urandom_range(0, 1));
        end else begin
            RX_DELAY_LINE_OUT_OF_RANGE = f;
            TX_DELAY_LINE_OUT_OF_RANGE = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        @(negedge FAB_CLK);
        drive_flags();
    endtask

    task automatic send(input bit op, input bit sel, input bit dir, input int taps,
                        input int a, output int acc);
        int w;
        REQ_VALID = 1'b1; REQ_OP = op; REQ_SEL = sel; REQ_DIR = dir; REQ_TAPS = 8'(taps);
        w = 0;
        while (!REQ_READY && w < 3000) begin
            tick();
            w++;
        end
        acc = -1;
        if (!REQ_READY) begin
            chk("ready_timeout", 0, 1);
        end else begin
            acc = cyc;
            model(op, sel, dir, taps, a, acc);
            cur_acc = acc; cur_a = a; cur_sel = sel;
            drive_flags();
            tick();
        end
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (q.size() != 0 && w < 3000) begin
            tick();
            w++;
        end
        chk("drain", q.size(), 0);
    endtask

    always @(negedge FAB_CLK) begin
        if (RESET) begin
            mv_seen = 0; ld_seen = 0; ps_seen = 0;
        end else begin
            if (DELAY_LINE_MOVE) begin
                mv_seen++;
                if (mq.size() == 0) chk("move_unexpected", cyc, -1);
                else                chk("move_cycle", cyc, mq.pop_front());
            end
            if (DELAY_LINE_LOAD) ld_seen++;
            if (HS_IO_CLK_PAUSE) ps_seen++;
            if (DONE) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", cyc, -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done);
                    chk("err", int'(ERR), e.err);
                    chk("move_count", int'(MOVE_COUNT), e.cnt);
                    chk("moves_seen", mv_seen, e.cnt);
                    chk("loads_seen", ld_seen, e.loads);
                    chk("pause_cycles", ps_seen, e.pause);
                    chk("sel", int'(DELAY_LINE_SEL), e.sel);
                    chk("dir", int'(DELAY_LINE_DIRECTION), e.dir);
                    chk("ready_at_done", int'(REQ_READY), 0);
                end
                mv_seen = 0; ld_seen = 0; ps_seen = 0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'(REQ_READY), 0);
        chk({tag, "_sel"},   int'(DELAY_LINE_SEL), 0);
        chk({tag, "_dir"},   int'(DELAY_LINE_DIRECTION), 0);
        chk({tag, "_load"},  int'(DELAY_LINE_LOAD), 0);
        chk({tag, "_move"},  int'(DELAY_LINE_MOVE), 0);
        chk({tag, "_pause"}, int'(HS_IO_CLK_PAUSE), 0);
        chk({tag, "_done"},  int'(DONE), 0);
        chk({tag, "_err"},   int'(ERR), 0);
        chk({tag, "_count"}, int'(MOVE_COUNT), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1;
        tick(); tick();
        chk_all_zero("reset");
        RESET = 1'b0;
        #1 chk("ready_after_reset", int'(REQ_READY), 1);

        tick();
        send(1'b0, 1'b1, 1'b1, 3, NEVER, a0);        wait_idle();
        send(1'b1, 1'b0, 1'b0, 0, 0, a0);            wait_idle();
        send(1'b0, 1'b1, 1'b0, 10, 12, a0);          wait_idle();
        send(1'b0, 1'b0, 1'b1, 0, NEVER, a0);
        send(1'b0, 1'b1, 1'b0, 2, NEVER, a1);
        chk("back_to_back_gap", a1 - a0, 2);
        wait_idle();
        send(1'b0, 1'b0, 1'b1, 5, 0, a0);            wait_idle();
        send(1'b0, 1'b1, 1'b1, 255, NEVER, a0);      wait_idle();

        send(1'b0, 1'b1, 1'b1, 5, NEVER, a0);
        while (cyc < a0 + 8) tick();
        RESET = 1'b1;
        q.delete();
        mq.delete();
        #1 chk_all_zero("midop_reset");
        tick(); tick();
        RESET = 1'b0;
        #1 chk("ready_after_midop", int'(REQ_READY), 1);
        tick();
        send(1'b0, 1'b1, 1'b0, 1, NEVER, a0);        wait_idle();

        for (int i = 0; i < 40; i++) begin
            bit op, sel, dir;
            int taps, a;
            op   = ($urandom_range(0, 3) == 0);
            sel  = 1'($urandom_range(0, 1));
            dir  = 1'($urandom_range(0, 1));
            taps = $urandom_range(0, 6);
            a    = ($urandom_range(0, 1) == 0) ? NEVER : $urandom_range(0, 30);
            send(op, sel, dir, taps, a, a0);
            if ($urandom_range(0, 2) == 0) wait_idle();
            else for (int j = 0; j < $urandom_range(0, 3); j++) tick();
        end
        wait_idle();
        chk("moves_left", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_lane_delay_ctrl.md
Name: ddr_lane_delay_ctrl

Overview:
- Fabric-side sequencer directly upstream of the DDR3 lane controller's delay-line control inputs.
- Accepts one load/move request at a time and generates the DELAY_LINE_SEL/LOAD/DIRECTION/MOVE pulse train with enforced spacing.
- Optionally brackets the update with HS_IO_CLK_PAUSE.
- Watches the lane's RX/TX out-of-range flags, aborts on limit, and reports the number of taps actually moved.

Parameters:
- MOVE_GAP, 4: cycles from one MOVE pulse to the next; legal values ≥ 2.
- PAUSE_SETUP, 2: cycles HS_IO_CLK_PAUSE is high before the first LOAD/MOVE pulse; legal values ≥ 1.
- PAUSE_HOLD, 2: cycles HS_IO_CLK_PAUSE stays high after the final gap; legal values ≥ 1.

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on the rising edge.
- RESET  in  1  asynchronous active-high reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY.
- REQ_OP  in  1  0 = move, 1 = load.
- REQ_SEL  in  1  0 = RX delay line, 1 = TX delay line.
- REQ_DIR  in  1  move direction, passed to DELAY_LINE_DIRECTION.
- REQ_TAPS  in  8  number of move pulses; ignored for load.
- DELAY_LINE_SEL  out  1  to lane controller.
- DELAY_LINE_LOAD  out  1  to lane controller.
- DELAY_LINE_DIRECTION  out  1  to lane controller.
- DELAY_LINE_MOVE  out  1  to lane controller.
- HS_IO_CLK_PAUSE  out  1  to lane controller.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = aborted on out-of-range.
- MOVE_COUNT  out  8  MOVE pulses issued in the last operation.

Behaviour:
- Clock and reset: one clock, FAB_CLK. RESET is asynchronous, active-high. While RESET is high, or mid-operation when it asserts, every output goes to 0 immediately, including REQ_READY, MOVE_COUNT and HS_IO_CLK_PAUSE. No DONE is issued for an interrupted operation. Operation resumes in IDLE on the first clock after release.
- Outputs are registered, except REQ_READY, which is 1 exactly in IDLE.
- States: IDLE, PAUSE_PRE, APPLY, GAP, PAUSE_POST, FINISH.
- IDLE: REQ_READY = 1.
  - On accept (cycle 0), latch SEL/DIR/OP/TAPS into DELAY_LINE_SEL and DELAY_LINE_DIRECTION, and clear MOVE_COUNT.
  - SEL and DIRECTION are held constant until the next accept.
- Zero-tap move (REQ_OP = 0, REQ_TAPS = 0): go directly to FINISH. No pause, no pulses, DONE at cycle 1, ERR = 0.
- PAUSE_PRE: HS_IO_CLK_PAUSE = 1 for PAUSE_SETUP cycles, then APPLY.
- APPLY (1 cycle):
  - Load: DELAY_LINE_LOAD = 1.
  - Move: DELAY_LINE_MOVE = 1, MOVE_COUNT += 1, remaining taps -= 1.
  - Then GAP.
- GAP: MOVE_GAP-1 cycles with LOAD and MOVE low. Each GAP cycle samples the out-of-range flag of the line selected by DELAY_LINE_SEL.
  - Flag high: abort, set error, go to PAUSE_POST (or FINISH if the pause feature is compiled out). No further pulses.
  - End of gap with taps remaining: APPLY.
  - End of gap otherwise: PAUSE_POST (or FINISH).
- PAUSE_POST: HS_IO_CLK_PAUSE stays 1 for PAUSE_HOLD cycles. It drops to 0 on entry to FINISH.
- FINISH (1 cycle): DONE = 1, ERR = error flag, REQ_READY = 0; then IDLE.
  - ERR and MOVE_COUNT hold until the next accept.
  - The out-of-range flag is never sampled during a load operation.
- Flag state at accept: flags are ignored during PAUSE_PRE and APPLY. A flag already high at accept therefore permits exactly one MOVE before the abort.
- Parameterised timing, with pause compiled in: HS_IO_CLK_PAUSE high on cycles 1..PAUSE_SETUP. MOVE k (k = 0..N-1) on cycle PAUSE_SETUP+1+k·MOVE_GAP. DONE on cycle PAUSE_SETUP+N·MOVE_GAP+PAUSE_HOLD+1.
- Worked example (MOVE_GAP=4, PAUSE_SETUP=2, PAUSE_HOLD=2, N=3): pause high on cycles 1–16, MOVE on cycles 3/7/11, DONE on cycle 17.
- Timing with pause compiled out: MOVE k on cycle 1+k·MOVE_GAP; DONE on cycle N·MOVE_GAP+1.
- MOVE_COUNT never wraps: REQ_TAPS ≤ 255 bounds it.

Optional Feature:
- Macro: DDR_LANE_DELAY_CTRL_PAUSE_EN.
- Defined: PAUSE_PRE and PAUSE_POST exist, and HS_IO_CLK_PAUSE brackets every non-zero operation as above.
- Undefined: HS_IO_CLK_PAUSE is tied to 0 and both pause states are removed. Transitions go IDLE→APPLY and GAP→FINISH; PAUSE_SETUP and PAUSE_HOLD have no effect.

Test Plan:
- Move, pause enabled, defaults: REQ_OP=0, SEL=1, DIR=1, TAPS=3 accepted at cycle 0 → MOVE pulses on cycles 3/7/11, pause high on cycles 1–16, DONE on cycle 17, ERR=0, MOVE_COUNT=3, DELAY_LINE_SEL=1 throughout.
- Load: REQ_OP=1, SEL=0 → exactly one LOAD pulse on cycle 3, no MOVE, DONE on cycle 9, MOVE_COUNT=0.
- Out-of-range abort: TAPS=10, SEL=1; TX_DELAY_LINE_OUT_OF_RANGE raised on cycle 12 → no MOVE after cycle 11, DONE with ERR=1, MOVE_COUNT=3. RX flag toggling in the same run has no effect.
- Zero taps plus back-to-back: TAPS=0 → DONE on cycle 1 with no pulses and no pause. REQ_VALID held high → next request accepted on cycle 2 (REQ_READY low on cycle 1).
- Reset mid-move: RESET asserted on cycle 8 of a 5-tap move → all outputs 0 asynchronously, no DONE. After release, REQ_READY=1 and a new 1-tap move completes normally.
- Macro undefined: TAPS=2 → MOVE on cycles 1/5, DONE on cycle 9, HS_IO_CLK_PAUSE constantly 0.
